// File: rtl/immgen_pkg.sv
// Shared opcodes, format codes and immediate-field extractors for the
// immediate-generation stage.
package immgen_pkg;

  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_R    = 3'd7
  } fmt_e;

  // Extractors return the immediate already sign-extended to 32 bits; the
  // decoder widens to XLEN afterwards.
  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_z(input logic [31:0] instr);
    return {27'b0, instr[19:15]};
  endfunction

endpackage

// File: rtl/immgen_decode.sv
// Combinational immediate decoder: format, XLEN-wide immediate and
// illegal-opcode flag for one instruction word.
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int EN_CSR = 1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic signed [31:0] imm32;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    imm32     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
        fmt_o = FMT_I;
        imm32 = imm_i(instr_i);
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          fmt_o = FMT_I;
          imm32 = imm_i(instr_i);
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm32 = imm_s(instr_i);
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm32 = imm_b(instr_i);
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm32 = imm_u(instr_i);
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm32 = imm_j(instr_i);
      end
      OPC_SYSTEM: begin
        // Only the immediate CSR forms (funct3[2] set) carry a zimm field.
        if ((EN_CSR != 0) && instr_i[14]) begin
          fmt_o = FMT_Z;
          imm32 = imm_z(instr_i);
        end
      end
      OPC_OP: begin
        fmt_o = FMT_R;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/immgen_stage.sv
// Registered immediate-generation stage: decodes at the input, holds the
// result in an output register with an optional one-entry skid behind it.
module immgen_stage
  import immgen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SKID   = 1,
  parameter int EN_CSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } word_t;

  word_t dec_w;
  word_t out_q, out_d;
  word_t skid_q, skid_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_fire;

  immgen_decode #(
    .XLEN   (XLEN),
    .EN_CSR (EN_CSR)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_w.imm),
    .fmt_o     (dec_w.fmt),
    .illegal_o (dec_w.illegal)
  );

  assign dec_w.instr = in_instr;

  // With a skid entry the ready is a pure flop output; without one it must
  // look through to the downstream ready to avoid a bubble.
  assign in_ready = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees this cycle: the skid word is older, so it wins.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec_w;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire && (SKID != 0)) begin
      skid_d       = dec_w;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: payload registers are reset too, because the output data itself
  // has defined reset values, not just the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_q.instr;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_immgen_stage.sv
// Directed bench: RV32 skid stage, RV64 skid stage and RV32 single-register
// stage share one input stream and are checked against hand-computed values.
module tb_immgen_stage;
  import immgen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_instr, a_out_imm;
  fmt_e        a_out_fmt;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [31:0] w_out_instr;
  logic [63:0] w_out_imm;
  fmt_e        w_out_fmt;

  logic        z_in_ready, z_out_valid, z_out_illegal;
  logic [31:0] z_out_instr, z_out_imm;
  fmt_e        z_out_fmt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  immgen_stage #(.XLEN(32), .SKID(1), .EN_CSR(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal)
  );

  immgen_stage #(.XLEN(64), .SKID(1), .EN_CSR(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_imm(w_out_imm), .out_fmt(w_out_fmt),
    .out_illegal(w_out_illegal)
  );

  immgen_stage #(.XLEN(32), .SKID(0), .EN_CSR(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_instr(z_out_instr), .out_imm(z_out_imm), .out_fmt(z_out_fmt),
    .out_illegal(z_out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the RV32 skid stage output word.
  task automatic check_a(input string tag, input logic [31:0] instr, input logic [31:0] imm,
                         input fmt_e fmt, input logic ill);
    check({tag, ".valid"},   64'(a_out_valid),   64'd1);
    check({tag, ".instr"},   64'(a_out_instr),   64'(instr));
    check({tag, ".imm"},     64'(a_out_imm),     64'(imm));
    check({tag, ".fmt"},     64'(a_out_fmt),     64'(fmt));
    check({tag, ".illegal"}, 64'(a_out_illegal), 64'(ill));
  endtask

  task automatic send(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst.valid",   64'(a_out_valid),   64'd0);
    check("rst.imm",     64'(a_out_imm),     64'd0);
    check("rst.fmt",     64'(a_out_fmt),     64'(FMT_NONE));
    check("rst.illegal", 64'(a_out_illegal), 64'd0);
    check("rst.instr",   64'(a_out_instr),   64'd0);
    check("rst.v64",     64'(w_out_valid),   64'd0);
    tick();
    check("rst.in_ready", 64'(a_in_ready), 64'd1);

    // addi x1,x0,-1
    send(32'hFFF00093);
    check_a("addi", 32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);
    check("addi.imm64",  w_out_imm,         64'hFFFFFFFFFFFFFFFF);
    check("addi.skid0",  64'(z_out_imm),    64'hFFFFFFFF);

    // Back-to-back sw, jal, csrrwi
    in_valid = 1'b1;
    in_instr = 32'hFE112E23;
    tick();
    check_a("sw", 32'hFE112E23, 32'hFFFFFFFC, FMT_S, 1'b0);
    in_instr = 32'hFFFFF06F;
    tick();
    check_a("jal", 32'hFFFFF06F, 32'hFFFFFFFE, FMT_J, 1'b0);
    check("jal.skid0", 64'(z_out_imm), 64'hFFFFFFFE);
    in_instr = 32'h300FD073;
    tick();
    check_a("csrrwi", 32'h300FD073, 32'h0000001F, FMT_Z, 1'b0);
    check("csrrwi.skid0", 64'(z_out_fmt), 64'(FMT_Z));
    in_valid = 1'b0;
    tick();
    check("drain.valid", 64'(a_out_valid), 64'd0);

    // lui: RV32 vs RV64 sign extension
    send(32'h800002B7);
    check_a("lui", 32'h800002B7, 32'h80000000, FMT_U, 1'b0);
    check("lui.imm64", w_out_imm,         64'hFFFFFFFF80000000);
    check("lui.fmt64", 64'(w_out_fmt),    64'(FMT_U));

    // addiw x1,x1,1: illegal at RV32, I-format at RV64
    send(32'h0010809B);
    check_a("addiw32", 32'h0010809B, 32'h0, FMT_NONE, 1'b1);
    check("addiw64.imm", w_out_imm,          64'd1);
    check("addiw64.fmt", 64'(w_out_fmt),     64'(FMT_I));
    check("addiw64.ill", 64'(w_out_illegal), 64'd0);

    // beq x0,x0,-4 ; add ; ecall ; all-zero word
    send(32'hFE000EE3);
    check_a("beq", 32'hFE000EE3, 32'hFFFFFFFC, FMT_B, 1'b0);
    send(32'h002081B3);
    check_a("add", 32'h002081B3, 32'h0, FMT_R, 1'b0);
    send(32'h00000073);
    check_a("ecall", 32'h00000073, 32'h0, FMT_NONE, 1'b0);
    send(32'h00000000);
    check_a("zero", 32'h00000000, 32'h0, FMT_NONE, 1'b1);
    tick();
    check("zero.drain", 64'(a_out_valid), 64'd0);

    // Stall with three offers: A to output, B to skid, C refused
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    check("stall.rdy0", 64'(a_in_ready), 64'd1);
    tick();
    check("stall.rdy1", 64'(a_in_ready), 64'd1);
    check("stall.z_rdy", 64'(z_in_ready), 64'd0);
    in_instr = 32'h00200093;
    tick();
    check("stall.rdy2", 64'(a_in_ready), 64'd0);
    in_instr = 32'h00300093;
    tick();
    check("stall.rdy3", 64'(a_in_ready), 64'd0);
    check_a("stall.hold", 32'h00100093, 32'd1, FMT_I, 1'b0);
    out_ready = 1'b1;
    #1;
    check("stall.z_rdy_comb", 64'(z_in_ready), 64'd1);
    tick();
    check_a("stall.outB", 32'h00200093, 32'd2, FMT_I, 1'b0);
    check("stall.rdy4", 64'(a_in_ready), 64'd1);
    tick();
    check_a("stall.outC", 32'h00300093, 32'd3, FMT_I, 1'b0);
    in_valid = 1'b0;
    tick();
    check("stall.drain", 64'(a_out_valid), 64'd0);

    // Reset with output and skid occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093;
    tick();
    in_instr  = 32'h00600093;
    tick();
    in_valid = 1'b0;
    check("full.rdy", 64'(a_in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.valid", 64'(a_out_valid), 64'd0);
    check("mrst.imm",   64'(a_out_imm),   64'd0);
    check("mrst.rdy",   64'(a_in_ready),  64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst.no_stale", 64'(a_out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
